mul_seq: RTL

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq_pkg.sv | 22 ++
 rtl/mul_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mul_seq_pkg.sv
// Shared constants for the mul_seq shift-and-add controller: ALU control words,
// FSM state encoding and iteration count.
package mul_seq_pkg;

    localparam int DATA_W     = 16;
    localparam int ITER_COUNT = 16;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ITER_COUNT - 1);

    // Control word bit order: ex, nx, ey, ny, f, no
    localparam logic [5:0] ALU_ADD   = 6'b101010;
    localparam logic [5:0] ALU_PASSX = 6'b100100;
    localparam logic [5:0] ALU_ZERO  = 6'b000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_seq.sv
// Sequential 16x16 shift-and-add multiplier controller driving an external ALU.
// Define MUL_SEQ_EARLY_EXIT_EN to stop iterating once the remaining multiplier is zero.
module mul_seq
    import mul_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              z_flag,
    output logic              lt_flag,
    output logic [DATA_W-1:0] alu_X,
    output logic [DATA_W-1:0] alu_Y,
    output logic [5:0]        alu_C,
    output logic              alu_en_bar,
    input  logic [DATA_W-1:0] alu_val
);

    state_t            state_q,  state_d;
    logic [DATA_W-1:0] acc_q,    acc_d;
    logic [DATA_W-1:0] mcand_q,  mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              z_q,      z_d;
    logic              lt_q,     lt_d;
    logic              done_q,   done_d;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            result_q <= '0;
            z_q      <= 1'b1;
            lt_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            result_q <= result_d;
            z_q      <= z_d;
            lt_q     <= lt_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        result_d = result_q;
        z_d      = z_q;
        lt_d     = lt_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = a;
                    mplier_d = b;
                    count_d  = '0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
                    state_d  = (b == '0) ? DONE : RUN;
`else
                    state_d  = RUN;
`endif
                end
            end
            RUN: begin
                acc_d    = alu_val;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == LAST_COUNT) begin
                    state_d = DONE;
                end
`ifdef MUL_SEQ_EARLY_EXIT_EN
                if (mplier_d == '0) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                result_d = acc_q;
                z_d      = (acc_q == '0);
                lt_d     = acc_q[DATA_W-1];
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The ALU adds the shifted multiplicand only when the current multiplier bit is set.
    always_comb begin
        alu_C = ALU_ZERO;
        if (state_q == RUN) begin
            alu_C = mplier_q[0] ? ALU_ADD : ALU_PASSX;
        end
    end

    assign alu_X      = acc_q;
    assign alu_Y      = mcand_q;
    assign alu_en_bar = 1'b1;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign result     = result_q;
    assign z_flag     = z_q;
    assign lt_flag    = lt_q;

endmodule
